// File: rtl/useq_pkg.sv
// Shared types and constants for the useq microcode step sequencer.
// The optional single-step release is built when USEQ_SSTEP_EN is defined.
package useq_pkg;

    localparam int IS_W             = 3;
    localparam int STEP_MAX_DEFAULT = 7;

    localparam logic [1:0] LEN_ILLEGAL = 2'd0;
    localparam logic [1:0] LEN_ONE     = 2'd1;
    localparam logic [1:0] LEN_THREE   = 2'd3;

`ifdef USEQ_SSTEP_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FI,
        ST_DEC,
        ST_FD1,
        ST_FD2,
        ST_EX,
        ST_HALT,
        ST_WAIT
    } useq_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FI,
        ST_DEC,
        ST_FD1,
        ST_FD2,
        ST_EX,
        ST_HALT
    } useq_state_t;
`endif

    // True in the three states that hold a memory read request open.
    function automatic logic is_fetch(input useq_state_t s);
        return (s == ST_FI) || (s == ST_FD1) || (s == ST_FD2);
    endfunction

endpackage

// File: rtl/useq_if.sv
// Handshake bundle between useq, instruction memory, decoder and PC.
// ss_go exists only when USEQ_SSTEP_EN is defined.
interface useq_if;
    import useq_pkg::*;

    logic            run;
    logic            mem_rdy;
    logic [1:0]      len;
    logic            uend;
    logic            trap;
    logic            stall;
`ifdef USEQ_SSTEP_EN
    logic            ss_go;
`endif
    logic [IS_W-1:0] is;
    logic            fetch_re;
    logic            ir_we;
    logic            d1_we;
    logic            d2_we;
    logic            pc_ini;
    logic            halted;
    logic            fault;

    // master: the surrounding machine; slave: the sequencer itself.
    modport master (
        output run, mem_rdy, len, uend, trap, stall,
`ifdef USEQ_SSTEP_EN
        output ss_go,
`endif
        input  is, fetch_re, ir_we, d1_we, d2_we, pc_ini, halted, fault
    );

    modport slave (
        input  run, mem_rdy, len, uend, trap, stall,
`ifdef USEQ_SSTEP_EN
        input  ss_go,
`endif
        output is, fetch_re, ir_we, d1_we, d2_we, pc_ini, halted, fault
    );

endinterface

// File: rtl/useq_edge.sv
// Registered rising-edge detector: o_rise pulses for one cycle, one cycle
// after i_lvl goes from 0 to 1. Reset clears the level history.
module useq_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_lvl;
            r_rise <= i_lvl & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/useq.sv
// useq: microcode step sequencer driving opcode/operand fetch, EX steps and HALT.
// Define USEQ_SSTEP_EN to add the ss_go single-step release and WAIT state.
module useq
    import useq_pkg::*;
#(
    parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    useq_if.slave bus
);

    localparam logic [IS_W-1:0] STEP_LAST = IS_W'(STEP_MAX);

    useq_state_t     r_state;
    logic [IS_W-1:0] r_is;
    logic [1:0]      r_len;
    logic            r_halted;
    logic            r_fault;

    useq_state_t     w_after_uend;

`ifdef USEQ_SSTEP_EN
    logic w_ss_rise;

    useq_edge u_edge (
        .clk    (clk),
        .rst_n  (rst),
        .i_lvl  (bus.ss_go),
        .o_rise (w_ss_rise)
    );

    assign w_after_uend = ST_WAIT;
`else
    assign w_after_uend = bus.run ? ST_FI : ST_IDLE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_is     <= '0;
            r_len    <= LEN_ILLEGAL;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_is <= '0;
                    if (bus.run)
                        r_state <= ST_FI;
                end

                ST_FI: begin
                    if (bus.mem_rdy)
                        r_state <= ST_DEC;
                end

                // len is only guaranteed valid here, so keep it for FD1.
                ST_DEC: begin
                    r_len <= bus.len;
                    if (bus.len == LEN_ILLEGAL) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_fault  <= 1'b1;
                    end else if (bus.len == LEN_ONE) begin
                        r_state <= ST_EX;
                    end else begin
                        r_state <= ST_FD1;
                    end
                end

                ST_FD1: begin
                    if (bus.mem_rdy)
                        r_state <= (r_len == LEN_THREE) ? ST_FD2 : ST_EX;
                end

                ST_FD2: begin
                    if (bus.mem_rdy)
                        r_state <= ST_EX;
                end

                ST_EX: begin
                    if (!bus.stall) begin
                        if (bus.trap) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (bus.uend) begin
                            r_is    <= '0;
                            r_state <= w_after_uend;
                        end else if (r_is == STEP_LAST) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_fault  <= 1'b1;
                        end else begin
                            r_is <= r_is + 1'b1;
                        end
                    end
                end

`ifdef USEQ_SSTEP_EN
                ST_WAIT: begin
                    if (w_ss_rise && bus.run)
                        r_state <= ST_FI;
                end
`endif

                ST_HALT: begin
                    r_state <= ST_HALT;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_is    <= '0;
                end
            endcase
        end
    end

    // Strobes complete in the handshake cycle, so they are decoded from state and mem_rdy.
    assign bus.fetch_re = is_fetch(r_state);
    assign bus.ir_we    = (r_state == ST_FI)  && bus.mem_rdy;
    assign bus.d1_we    = (r_state == ST_FD1) && bus.mem_rdy;
    assign bus.d2_we    = (r_state == ST_FD2) && bus.mem_rdy;
    assign bus.pc_ini   = is_fetch(r_state) && bus.mem_rdy;

    assign bus.is       = r_is;
    assign bus.halted   = r_halted;
    assign bus.fault    = r_fault;

endmodule

// File: tb/tb_useq.sv
// Self-checking bench for useq: per-cycle vector table plus hand sequences
// for illegal length, step overflow with stall, trap priority, async reset and single-step.
module tb_useq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    useq_if bus ();

    useq dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fetch_re, ir_we, d1_we, d2_we, pc_ini, halted, fault}
    logic [6:0] w_out;
    assign w_out = {bus.fetch_re, bus.ir_we, bus.d1_we, bus.d2_we, bus.pc_ini, bus.halted, bus.fault};

    typedef struct {
        logic       run;
        logic       rdy;
        logic [1:0] len;
        logic       uend;
        logic       trap;
        logic       stall;
        logic [2:0] e_is;
        logic [6:0] e_out;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic run, input logic rdy, input logic [1:0] len,
                         input logic uend, input logic trap, input logic stall);
        bus.run     = run;
        bus.mem_rdy = rdy;
        bus.len     = len;
        bus.uend    = uend;
        bus.trap    = trap;
        bus.stall   = stall;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`ifdef USEQ_SSTEP_EN
        bus.ss_go = 1'b0;
`endif
        rst_n = 1'b0;
        tick(2);
        check("reset_out", {25'd0, w_out}, 32'd0);
        check("reset_is", {29'd0, bus.is}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc_total;
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;

        // run, rdy, len, uend, trap, stall, expected is, expected strobes/flags
        vecs[0]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // IDLE
        vecs[1]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1100100}; // FI, opcode
        vecs[2]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // DEC len=1
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // EX 0
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd1, 7'b0000000}; // EX 1
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 3'd2, 7'b0000000}; // EX 2 uend
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1000000}; // FI wait, run=0
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1100100}; // FI, opcode
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // DEC len=3
        vecs[9]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1000000}; // FD1 wait
        vecs[10] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1000000}; // FD1 wait
        vecs[11] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1010100}; // FD1 operand 1
        vecs[12] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1001100}; // FD2 operand 2
        vecs[13] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 7'b0000000}; // EX 0 uend, run=0
        vecs[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // IDLE
        vecs[15] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // IDLE
        vecs[16] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // IDLE, run=1
        vecs[17] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1100100}; // FI
        vecs[18] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // DEC len=2
        vecs[19] = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1010100}; // FD1 -> EX
        vecs[20] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000}; // EX 0
        vecs[21] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 3'd1, 7'b0000000}; // EX 1 stalled
        vecs[22] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd1, 7'b0000000}; // EX 1 uend
        vecs[23] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 3'd0, 7'b1000000}; // FI again

        do_reset();

`ifndef USEQ_SSTEP_EN
        pc_total = 0;
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].run, vecs[i].rdy, vecs[i].len, vecs[i].uend, vecs[i].trap, vecs[i].stall);
            #1;
            check($sformatf("vec%0d_out", i), {25'd0, w_out}, {25'd0, vecs[i].e_out});
            check($sformatf("vec%0d_is", i), {29'd0, bus.is}, {29'd0, vecs[i].e_is});
            if (bus.pc_ini) pc_total++;
            tick(1);
        end
        check("pc_ini_total", pc_total, 6);
`endif

        // Illegal length: HALT with fault, then ignore run/mem_rdy.
        do_reset();
        drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("illegal_out", {25'd0, w_out}, {25'd0, 7'b0000011});
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("halt_hold%0d", i), {25'd0, w_out}, {25'd0, 7'b0000011});
        end

        // Step overflow with a 3-cycle stall at is=4.
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("ovf_ex_entry_is", {29'd0, bus.is}, 32'd0);
        tick(4);
        check("ovf_is4", {29'd0, bus.is}, 32'd4);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("stall_is%0d", i), {29'd0, bus.is}, 32'd4);
        end
        bus.stall = 1'b0;
        tick(3);
        check("ovf_is7", {29'd0, bus.is}, 32'd7);
        check("ovf_not_halted", {31'd0, bus.halted}, 32'd0);
        tick(1);
        check("ovf_halt", {25'd0, w_out}, {25'd0, 7'b0000011});

        // Async reset out of HALT, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_halt_out", {25'd0, w_out}, 32'd0);
        check("arst_halt_is", {29'd0, bus.is}, 32'd0);
        tick(1);
        rst_n = 1'b1;

        // trap and uend together: trap wins, no fault.
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check("trap_is1", {29'd0, bus.is}, 32'd1);
        bus.trap = 1'b1;
        bus.uend = 1'b1;
        tick(1);
        check("trap_halt", {25'd0, w_out}, {25'd0, 7'b0000010});

        // Async reset while operand 1 is being fetched.
        do_reset();
        drive(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("fd1_strobe", {25'd0, w_out}, {25'd0, 7'b1010100});
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fd1_out", {25'd0, w_out}, 32'd0);
        tick(1);
        rst_n = 1'b1;

`ifdef USEQ_SSTEP_EN
        // Single-step: a level held for 5 cycles releases one instruction.
        do_reset();
        drive(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        tick(4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("wait_idle%0d", i), {25'd0, w_out}, 32'd0);
            tick(1);
        end
        cnt = 0;
        bus.ss_go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) bus.ss_go = 1'b0;
            #1;
            if (bus.ir_we) cnt++;
            tick(1);
        end
        check("ss_level_one_instr", cnt, 1);
        cnt = 0;
        bus.ss_go = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) bus.ss_go = 1'b0;
            #1;
            if (bus.ir_we) cnt++;
            tick(1);
        end
        check("ss_pulse_one_instr", cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
